mem_io_responder: RTL and testbench

//  Memory-side responder for the simple RISC CPU's data/instruction bus.
//  - Accepts single read/write requests from the CPU (bus initiator) on a req/ack handshake.
//  - Serves them from an internal 2^ADDR_W x DATA_W RAM after a programmable wait.
//  - Maps one address (OUT_ADDR) to the `out` register, the value the system benches sample.

---
 rtl/mem_io_responder_if.sv | 14 +
 rtl/mem_io_responder.sv | 70 +++++++
 tb/tb_mem_io_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU-to-memory req/ack bus
interface mem_io_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: RAM plus memory-mapped out register behind a req/ack bus with programmable wait states
module mem_io_responder #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] OUT_ADDR    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_io_responder_if.slave bus,
  output logic [DATA_W-1:0] out,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  localparam logic [3:0] CNT_LOAD = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ram_we;
  // With zero wait states the read is launched straight from the live bus in IDLE.
  assign rd_addr = state == S_IDLE ? bus.mem_addr : addr_q;
  assign rd_data = rd_addr == OUT_ADDR ? out : ram[rd_addr];
  assign ram_we  = state == S_ACK && we_q && addr_q != OUT_ADDR;
  assign busy    = state != S_IDLE;
  always_ff @(posedge clk)
    if (ram_we) ram[addr_q] <= wdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      out           <= '0;
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.mem_req) begin
            we_q    <= bus.mem_we;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            cnt     <= CNT_LOAD;
            if (WAIT_CYCLES == 0) begin
              state       <= S_ACK;
              bus.mem_ack <= 1'b1;
              if (!bus.mem_we) bus.mem_rdata <= rd_data;
            end else state <= S_WAIT;
          end
        S_WAIT:
          if (cnt == 4'd0) begin
            state       <= S_ACK;
            bus.mem_ack <= 1'b1;
            if (!we_q) bus.mem_rdata <= rd_data;
          end else cnt <= cnt - 4'd1;
        S_ACK: begin
          state       <= S_IDLE;
          bus.mem_ack <= 1'b0;
          if (we_q && addr_q == OUT_ADDR) out <= wdata_q;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized scoreboard bench for mem_io_responder
module tb_mem_io_responder;
  localparam int W = 1;
  typedef struct {
    bit          rd;
    bit          known;
    logic [15:0] data;
    logic [15:0] out_after;
    int          acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mem_io_responder_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
  mem_io_responder_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
  logic [15:0] out0, out1;
  logic        busy0, busy1;
  mem_io_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W), .OUT_ADDR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .out(out0), .busy(busy0));
  mem_io_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0), .OUT_ADDR(8'hFF)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .out(out1), .busy(busy1));
  exp_t        q[$];
  int          tests = 0, fails = 0, cyc = 0;
  bit          rst_seen = 0, chk_out = 0;
  logic [15:0] exp_out;
  logic [15:0] m_ram [256];
  bit          m_valid [256];
  logic [15:0] m_out = 16'h0;
  logic [7:0]  pool [8];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  // Scoreboard monitor: pops one expectation per ack seen on the main DUT.
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      chk_out = 0;
      rst_seen = 1;
    end else if (rst_seen) begin
      if (chk_out) begin
        check("out_after_ack", out0, exp_out);
        chk_out = 0;
      end
      if (b0.mem_ack) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack got ack=1 expected none at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          check("ack_latency", cyc - e.acc, W);
          if (e.rd && e.known) check("rdata", b0.mem_rdata, e.data);
          exp_out = e.out_after;
          chk_out = 1;
        end
      end
    end
  end
  // mode 0: hold request until ack; 1: scramble inputs and drop req; 2: scramble and keep req high
  task automatic xact(bit we, logic [7:0] a, logic [15:0] d, int mode);
    exp_t e;
    int   n;
    e.rd = !we;
    e.known = a == 8'hFF || m_valid[a];
    e.data = a == 8'hFF ? m_out : m_ram[a];
    e.acc = cyc + 1;
    if (we) begin
      if (a == 8'hFF) m_out = d;
      else begin
        m_ram[a] = d;
        m_valid[a] = 1;
      end
    end
    e.out_after = m_out;
    q.push_back(e);
    b0.mem_req = 1'b1;
    b0.mem_we = we;
    b0.mem_addr = a;
    b0.mem_wdata = d;
    @(negedge clk);
    if (mode != 0) begin
      b0.mem_addr = 8'($urandom);
      b0.mem_wdata = 16'($urandom);
      b0.mem_we = 1'($urandom);
      b0.mem_req = mode == 2;
    end
    n = 0;
    while (!b0.mem_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!b0.mem_ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout got no ack expected ack within 40 cycles at cycle %0d", cyc);
    end
    b0.mem_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_out"}, out0, 16'h0);
    check({tag, "_ack"}, b0.mem_ack, 1'b0);
    check({tag, "_busy"}, busy0, 1'b0);
    check({tag, "_rdata"}, b0.mem_rdata, 16'h0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0]  a;
    logic [15:0] reqs_d [4];
    logic [7:0]  reqs_a [4];
    bit          reqs_w [4];
    int          idx, acks, last;
    {b0.mem_req, b0.mem_we, b0.mem_addr, b0.mem_wdata} = '0;
    {b1.mem_req, b1.mem_we, b1.mem_addr, b1.mem_wdata} = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1, 8'h10, 16'h5555, 0);
    xact(0, 8'h10, 16'h0, 0);
    check("out_untouched", out0, 16'h0);
    xact(1, 8'hFF, 16'hFFFF, 0);
    check("out_written", out0, 16'hFFFF);
    xact(0, 8'hFF, 16'h0, 0);
    xact(1, 8'h20, 16'h1234, 1);
    xact(0, 8'h20, 16'h0, 0);
    b0.mem_req = 1'b1;
    b0.mem_we = 1'b1;
    b0.mem_addr = 8'hFF;
    b0.mem_wdata = 16'hAAAA;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    b0.mem_req = 1'b0;
    m_out = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("out_after_abort", out0, 16'h0);
    xact(0, 8'hFF, 16'h0, 0);
    xact(0, 8'h10, 16'h0, 0);
    pool[0] = 8'hFF;
    for (int i = 1; i < 8; i++) pool[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 8; i++) xact(1, pool[i], 16'($urandom), 0);
    for (int i = 0; i < 60; i++) begin
      a = pool[$urandom_range(0, 7)];
      xact(1'($urandom), a, 16'($urandom), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    reqs_w = '{1, 0, 1, 0};
    reqs_a = '{8'h30, 8'h30, 8'hFF, 8'hFF};
    reqs_d = '{16'hA5A5, 16'h0, 16'h0F0F, 16'h0};
    idx = 0;
    acks = 0;
    last = 0;
    b1.mem_req = 1'b1;
    b1.mem_we = reqs_w[0];
    b1.mem_addr = reqs_a[0];
    b1.mem_wdata = reqs_d[0];
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (b1.mem_ack) begin
        acks++;
        if (acks > 1) check("zero_wait_spacing", cyc - last, 2);
        last = cyc;
        if (idx == 1) check("zero_wait_rdata_ram", b1.mem_rdata, 16'hA5A5);
        if (idx == 3) check("zero_wait_rdata_out", b1.mem_rdata, 16'h0F0F);
        idx++;
        if (idx < 4) begin
          b1.mem_we = reqs_w[idx];
          b1.mem_addr = reqs_a[idx];
          b1.mem_wdata = reqs_d[idx];
        end else b1.mem_req = 1'b0;
      end
    end
    check("zero_wait_ack_count", acks, 4);
    check("zero_wait_idle", busy1, 1'b0);
    check("zero_wait_out", out1, 16'h0F0F);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
